// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder
//   Captures the serial device-select bits that open each bus transaction,
//   selects the matching slave, and then steers the master's handshakes to
//   that slave until the grant drops. Also handles slave splits (the select
//   is held while the slave is split and reused when the master is
//   re-granted), and reports decode errors and capture timeouts.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   bgrant               a master holds the bus
//   m_wr_bus             serial write bit from the master (broadcast to slaves)
//   m_master_valid/ready master bit-valid / master ready for a read bit
//   m_slave_ready/valid  ready / read-valid returned to the master
//   m_rd_bus             serial read bit returned to the master
//   ack, dec_err         one-cycle pulses: accepted / bad index or timeout
//   split                selected slave is split (to the arbiter)
//   s_sel                one-hot registered slave select
//   s_wr_bus             broadcast write bit
//   s_master_valid/ready per-slave copies, only the selected bit can be high
//   s_slave_ready/valid, s_rd_bus, s_split   per-slave inputs
module bus_addr_decoder #(
  parameter int NUM_SLAVES = 3,
  parameter int DEV_BITS   = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bgrant,
  input  logic                  m_wr_bus,
  input  logic                  m_master_valid,
  input  logic                  m_master_ready,
  output logic                  m_slave_ready,
  output logic                  m_slave_valid,
  output logic                  m_rd_bus,
  output logic                  ack,
  output logic                  dec_err,
  output logic                  split,
  output logic [NUM_SLAVES-1:0] s_sel,
  output logic                  s_wr_bus,
  output logic [NUM_SLAVES-1:0] s_master_valid,
  output logic [NUM_SLAVES-1:0] s_master_ready,
  input  logic [NUM_SLAVES-1:0] s_slave_ready,
  input  logic [NUM_SLAVES-1:0] s_slave_valid,
  input  logic [NUM_SLAVES-1:0] s_rd_bus,
  input  logic [NUM_SLAVES-1:0] s_split
);

  localparam int CW = $clog2(DEV_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, ACK, ROUTE, SPLIT, RESUME} state_t;

  state_t                state_q, state_d;
  logic [DEV_BITS-1:0]   dev_q, dev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  // Shift path. The register's top bit is always 0 when the last bit
  // arrives (only DEV_BITS-1 bits were shifted in from zero), so the
  // extended value can be used directly as the decoded index.
  logic [DEV_BITS:0]     dev_ext;
  logic [31:0]           idx;
  logic [NUM_SLAVES-1:0] onehot;
  logic                  idx_ok;
  logic [CW-1:0]         cnt_inc;
  logic [TW-1:0]         tcnt_inc;
  logic                  sel_split;

  assign dev_ext   = {dev_q, m_wr_bus};
  assign idx       = 32'(dev_ext);
  assign idx_ok    = idx < 32'(NUM_SLAVES);
  assign cnt_inc   = cnt_q + CW'(1);
  assign tcnt_inc  = tcnt_q + TW'(1);
  assign sel_split = |(s_split & sel_q);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) onehot[i] = (idx == 32'(i));
  end

  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      // cnt_q is 0 in IDLE, so both states share the capture path; with
      // DEV_BITS==1 the first bit decodes straight from IDLE.
      IDLE, ADDR: begin
        if (!bgrant) begin
          state_d = IDLE;
          dev_d   = '0;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else if (m_master_valid) begin
          tcnt_d = '0;
          if (cnt_inc == CW'(DEV_BITS)) begin
            dev_d = '0;
            cnt_d = '0;
            if (idx_ok) begin
              sel_d   = onehot;
              state_d = ACK;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            dev_d   = dev_ext[DEV_BITS-1:0];
            cnt_d   = cnt_inc;
            state_d = ADDR;
          end
        end else if (state_q == ADDR) begin
          if (tcnt_inc == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            dev_d   = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      ACK: begin
        if (!bgrant) begin
          sel_d   = '0;
          state_d = IDLE;
        end else begin
          ack_d   = 1'b1;
          state_d = ROUTE;
        end
      end
      ROUTE: begin
        // A split wins over a grant drop in the same cycle.
        if (sel_split) state_d = SPLIT;
        else if (!bgrant) begin
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      SPLIT:   if (!sel_split) state_d = RESUME;
      RESUME:  if (bgrant) state_d = ROUTE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dev_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  logic route;
  assign route = (state_q == ROUTE);

  always_comb begin
    m_slave_ready = 1'b0;
    case (state_q)
      IDLE:    m_slave_ready = bgrant & rstn;  // keep outputs low while in reset
      ADDR:    m_slave_ready = 1'b1;
      ROUTE:   m_slave_ready = |(sel_q & s_slave_ready);
      default: m_slave_ready = 1'b0;
    endcase
  end

  assign m_slave_valid  = route & |(sel_q & s_slave_valid);
  assign m_rd_bus       = route & |(sel_q & s_rd_bus);
  assign s_master_valid = route ? (sel_q & {NUM_SLAVES{m_master_valid}}) : '0;
  assign s_master_ready = route ? (sel_q & {NUM_SLAVES{m_master_ready}}) : '0;
  assign split          = (state_q == SPLIT) & sel_split;
  assign s_sel          = sel_q;
  assign s_wr_bus       = m_wr_bus;
  assign ack            = ack_q;
  assign dec_err        = err_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Testbench for bus_addr_decoder: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (bit list value, idle count, selected index and
// a phase for the held select).
module tb_bus_addr_decoder;
  localparam int NS = 3;
  localparam int DB = 2;
  localparam int TO = 16;

  logic clk = 1'b0, rstn = 1'b0, bgrant = 1'b0;
  logic m_wr_bus = 1'b0, m_master_valid = 1'b0, m_master_ready = 1'b0;
  logic m_slave_ready, m_slave_valid, m_rd_bus, ack, dec_err, split, s_wr_bus;
  logic [NS-1:0] s_sel, s_master_valid, s_master_ready;
  logic [NS-1:0] s_slave_ready = '0, s_slave_valid = '0, s_rd_bus = '0, s_split = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_addr_decoder #(.NUM_SLAVES(NS), .DEV_BITS(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .bgrant(bgrant), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
    .m_rd_bus(m_rd_bus), .ack(ack), .dec_err(dec_err), .split(split),
    .s_sel(s_sel), .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_slave_ready(s_slave_ready),
    .s_slave_valid(s_slave_valid), .s_rd_bus(s_rd_bus), .s_split(s_split)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_ACK = 0, P_ROUTE = 1, P_SPLIT = 2, P_RESUME = 3;
  int m_nbits = 0, m_val = 0, m_idle = 0, m_sel = -1, m_phase = 0;
  bit m_ack = 0, m_err = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_nbits = 0; m_val = 0; m_idle = 0; m_sel = -1; m_phase = 0;
      m_ack = 0; m_err = 0;
    end else begin
      m_ack = 0;
      m_err = 0;
      if (m_sel < 0) begin
        if (!bgrant) begin
          m_nbits = 0; m_val = 0; m_idle = 0;
        end else if (m_master_valid) begin
          m_val = m_val * 2 + int'(m_wr_bus);
          m_nbits++;
          m_idle = 0;
          if (m_nbits == DB) begin
            if (m_val < NS) begin m_sel = m_val; m_phase = P_ACK; end
            else m_err = 1;
            m_nbits = 0; m_val = 0;
          end
        end else if (m_nbits > 0) begin
          m_idle++;
          if (m_idle == TO) begin
            m_err = 1; m_nbits = 0; m_val = 0; m_idle = 0;
          end
        end
      end else begin
        case (m_phase)
          P_ACK:    if (!bgrant) m_sel = -1; else begin m_ack = 1; m_phase = P_ROUTE; end
          P_ROUTE:  if (s_split[m_sel]) m_phase = P_SPLIT; else if (!bgrant) m_sel = -1;
          P_SPLIT:  if (!s_split[m_sel]) m_phase = P_RESUME;
          default:  if (bgrant) m_phase = P_ROUTE;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp_blk
    logic [NS-1:0] e_sel, e_smv, e_smr;
    logic rt, e_msr, e_msv, e_rd, e_split;
    e_sel = '0; e_smv = '0; e_smr = '0;
    e_msv = 1'b0; e_rd = 1'b0; e_split = 1'b0;
    rt = (m_sel >= 0) && (m_phase == P_ROUTE);
    if (m_sel >= 0) begin
      e_sel[m_sel] = 1'b1;
      e_msr = 1'b0;
      if (rt) begin
        e_smv[m_sel] = m_master_valid;
        e_smr[m_sel] = m_master_ready;
        e_msr = s_slave_ready[m_sel];
        e_msv = s_slave_valid[m_sel];
        e_rd  = s_rd_bus[m_sel];
      end
      if (m_phase == P_SPLIT) e_split = s_split[m_sel];
    end else begin
      e_msr = (m_nbits > 0) || (bgrant && rstn);
    end
    cmp("s_sel", 32'(s_sel), 32'(e_sel));
    cmp("ack", 32'(ack), 32'(m_ack));
    cmp("dec_err", 32'(dec_err), 32'(m_err));
    cmp("split", 32'(split), 32'(e_split));
    cmp("m_slave_ready", 32'(m_slave_ready), 32'(e_msr));
    cmp("m_slave_valid", 32'(m_slave_valid), 32'(e_msv));
    cmp("m_rd_bus", 32'(m_rd_bus), 32'(e_rd));
    cmp("s_master_valid", 32'(s_master_valid), 32'(e_smv));
    cmp("s_master_ready", 32'(s_master_ready), 32'(e_smr));
    cmp("s_wr_bus", 32'(s_wr_bus), 32'(m_wr_bus));
    cmp("sel_onehot0", 32'($onehot0(s_sel)), 32'd1);
    cmp("ack_and_err", 32'(ack & dec_err), 32'd0);
  end

  task automatic step(input logic bg, input logic v, input logic wr);
    bgrant = bg; m_master_valid = v; m_wr_bus = wr;
    @(posedge clk); #1;
  endtask

  logic vrare;

  initial begin
    repeat (3) @(posedge clk); #1;
    cmp("rst_sel", 32'(s_sel), 32'd0);
    cmp("rst_ack", 32'(ack), 32'd0);
    cmp("rst_err", 32'(dec_err), 32'd0);
    cmp("rst_msr", 32'(m_slave_ready), 32'd0);
    rstn = 1'b1;

    // decode index 2, ack two cycles after the second bit
    m_master_ready = 1'b1; s_slave_ready = 3'b100;
    step(1, 1, 1); step(1, 1, 0);
    cmp("t1_sel", 32'(s_sel), 32'b100);
    cmp("t1_ack_early", 32'(ack), 32'd0);
    cmp("t1_model_sel", 32'(m_sel), 32'd2);
    step(1, 0, 0);
    cmp("t1_ack", 32'(ack), 32'd1);
    s_slave_valid = 3'b100; s_rd_bus = 3'b100; m_master_valid = 1'b1; #1;
    cmp("t1_msv", 32'(m_slave_valid), 32'd1);
    cmp("t1_rd", 32'(m_rd_bus), 32'd1);
    cmp("t1_smv", 32'(s_master_valid), 32'b100);
    step(1, 1, 0);
    cmp("t1_ack_once", 32'(ack), 32'd0);
    s_slave_valid = 3'b011; s_rd_bus = 3'b011; #1;
    cmp("t1_msv0", 32'(m_slave_valid), 32'd0);

    // bad index 3
    step(0, 0, 0);
    cmp("t2_sel_clr", 32'(s_sel), 32'd0);
    step(1, 1, 1); step(1, 1, 1);
    cmp("t2_err", 32'(dec_err), 32'd1);
    cmp("t2_ack", 32'(ack), 32'd0);
    cmp("t2_sel", 32'(s_sel), 32'd0);
    step(1, 0, 0);
    cmp("t2_err_pulse", 32'(dec_err), 32'd0);

    // capture timeout, then clean decode of index 1
    step(1, 1, 0);
    repeat (TO - 1) step(1, 0, 0);
    cmp("t3_no_err", 32'(dec_err), 32'd0);
    step(1, 0, 0);
    cmp("t3_timeout", 32'(dec_err), 32'd1);
    step(1, 1, 0); step(1, 1, 1);
    cmp("t3_sel", 32'(s_sel), 32'b010);
    cmp("t3_err_clear", 32'(dec_err), 32'd0);

    // split and resume
    step(1, 0, 0);
    cmp("t4_ack", 32'(ack), 32'd1);
    s_split = 3'b010;
    step(1, 0, 0);
    cmp("t4_split", 32'(split), 32'd1);
    s_slave_valid = 3'b111; s_slave_ready = 3'b111; s_rd_bus = 3'b111; m_master_valid = 1'b1; #1;
    cmp("t4_msv", 32'(m_slave_valid), 32'd0);
    cmp("t4_msr", 32'(m_slave_ready), 32'd0);
    cmp("t4_rd", 32'(m_rd_bus), 32'd0);
    cmp("t4_smv", 32'(s_master_valid), 32'd0);
    step(0, 0, 0);
    cmp("t4_hold", 32'(split), 32'd1);
    cmp("t4_sel_hold", 32'(s_sel), 32'b010);
    s_split = '0; #1;
    cmp("t4_split_fall", 32'(split), 32'd0);
    step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
    cmp("t4_sel", 32'(s_sel), 32'b010);
    cmp("t4_noack", 32'(ack), 32'd0);
    m_master_valid = 1'b1; #1;
    cmp("t4_smv_route", 32'(s_master_valid), 32'b010);

    // split and grant drop together
    s_split = 3'b010;
    step(0, 0, 0);
    cmp("t5_split", 32'(split), 32'd1);
    cmp("t5_sel", 32'(s_sel), 32'b010);
    s_split = '0;
    step(0, 0, 0); step(1, 0, 0);

    // async reset mid-route
    m_master_valid = 1'b1; #1;
    cmp("t6_pre", 32'(m_slave_valid), 32'd1);
    rstn = 1'b0; #1;
    cmp("t6_sel", 32'(s_sel), 32'd0);
    cmp("t6_msv", 32'(m_slave_valid), 32'd0);
    cmp("t6_rd", 32'(m_rd_bus), 32'd0);
    cmp("t6_msr", 32'(m_slave_ready), 32'd0);
    cmp("t6_smv", 32'(s_master_valid), 32'd0);
    step(1, 0, 0);
    rstn = 1'b1;
    step(1, 1, 0); step(1, 1, 0);
    cmp("t6_sel_new", 32'(s_sel), 32'b001);

    // randomized traffic, checked by the model every cycle
    vrare = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 128 == 0) vrare = ($urandom_range(0, 2) == 0);
      s_slave_ready = NS'($urandom);
      s_slave_valid = NS'($urandom);
      s_rd_bus      = NS'($urandom);
      m_master_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) s_split = ($urandom_range(0, 1) == 1) ? NS'($urandom) : '0;
      rstn = ($urandom_range(0, 699) != 0);
      step($urandom_range(0, 19) != 0,
           vrare ? ($urandom_range(0, 39) == 0) : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    rstn = 1'b1;
    step(0, 0, 0);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
